// File: rtl/pwm_multichannel.sv
// pwm_multichannel: NUM_CH PWM outputs driven from one shared period counter.
// Edge-aligned (period MAX) or center-aligned (period 2*MAX) operation, with a
// run/stop control and a one-cycle period-end strobe.
// Optional feature macro: PWM_SHADOW_EN. When defined, each compare value is a
// shadow of its duty register, reloaded only at the period boundary (or
// directly while stopped). When undefined, compare follows duty immediately.
module pwm_multichannel #(
   parameter int NUM_CH = 16,
   parameter int CNT_W  = 8,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [CNT_W-1:0]  wr_data,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              period_end
);

   // Last counter value before the wrap / turnaround (MAX-1).
   localparam logic [CNT_W-1:0]  CNT_TOP   = {{(CNT_W-1){1'b1}}, 1'b0};
   localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NUM_CH);

   logic              ctrl_wr;
   logic              run_q, run_d;
   logic              center_q, center_d;   // CENTER bit as written
   logic              mode_q, mode_d;       // CENTER bit currently in effect
   logic              dir_q, dir_d;         // 0 = counting up, 1 = counting down
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              running;
   logic              boundary;
   logic [NUM_CH-1:0] pwm_q, pwm_d;
   logic              pe_q;

   assign ctrl_wr  = wr_en && (wr_addr == CTRL_ADDR);
   // Stays in the counting branch only if running now and not being stopped.
   assign running  = run_q && run_d;
   // Last cycle of the period for the mode currently in effect.
   assign boundary = run_q && (mode_q ? ((cnt_q == '0) && dir_q)
                                      : (cnt_q == CNT_TOP));

`ifdef PWM_SHADOW_EN
   logic cmp_load;
   // Shadows reload while stopped and at each boundary, with same-cycle writes forwarded.
   assign cmp_load = !running || boundary;
`endif

   // Per-channel duty register, compare source and comparator.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
         logic [CNT_W-1:0] duty_q, duty_d;
         logic [CNT_W-1:0] cmp;
         logic             duty_wr;

         assign duty_wr = wr_en && (wr_addr == ADDR_W'(gi));
         assign duty_d  = duty_wr ? wr_data : duty_q;

         // Duty register updates on the write edge.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) duty_q <= '0;
            else        duty_q <= duty_d;
         end

`ifdef PWM_SHADOW_EN
         logic [CNT_W-1:0] cmp_q;
         // Shadow compare register: glitch-free duty change per period.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)        cmp_q <= '0;
            else if (cmp_load) cmp_q <= duty_d;
         end
         assign cmp = cmp_q;
`else
         assign cmp = duty_q;
`endif

         assign pwm_d[gi] = run_q && (cnt_q < cmp);
      end
   endgenerate

   // CTRL write decode: RUN and CENTER bits, upper data bits ignored.
   always_comb begin
      run_d    = run_q;
      center_d = center_q;
      if (ctrl_wr) begin
         run_d    = wr_data[0];
         center_d = wr_data[1];
      end
   end

   // Counter, direction and active mode: hold while stopped, restart at boundary.
   always_comb begin
      cnt_d  = cnt_q;
      dir_d  = dir_q;
      mode_d = mode_q;
      if (!running || boundary) begin
         cnt_d  = '0;
         dir_d  = 1'b0;
         mode_d = center_d;
      end else if (!mode_q) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!dir_q) begin
         if (cnt_q == CNT_TOP) dir_d = 1'b1;   // hold the top value a second cycle
         else                  cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q    <= 1'b0;
         center_q <= 1'b0;
         mode_q   <= 1'b0;
         dir_q    <= 1'b0;
         cnt_q    <= '0;
         pwm_q    <= '0;
         pe_q     <= 1'b0;
      end else begin
         run_q    <= run_d;
         center_q <= center_d;
         mode_q   <= mode_d;
         dir_q    <= dir_d;
         cnt_q    <= cnt_d;
         pwm_q    <= pwm_d;
         pe_q     <= boundary;
      end
   end

   assign pwm_out    = pwm_q;
   assign period_end = pe_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel: directed and randomized stimulus against a phase-based
// behavioural model; outputs compared every cycle plus literal expectations.
module tb_pwm_multichannel;

   localparam int NUM_CH = 16;
   localparam int CNT_W  = 8;
   localparam int ADDR_W = 5;
   localparam int MAXV   = 255;
`ifdef PWM_SHADOW_EN
   localparam bit SHADOW = 1'b1;
`else
   localparam bit SHADOW = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              wr_en = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [CNT_W-1:0]  wr_data = '0;
   logic [NUM_CH-1:0] pwm_out;
   logic              period_end;

   int checks = 0;
   int errors = 0;

   pwm_multichannel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .pwm_out(pwm_out), .period_end(period_end)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // State is a phase index within the period; counter value is derived.
   bit                m_run = 0, m_center = 0, m_mode = 0;
   int                m_p = 0;
   int                m_duty [NUM_CH];
   int                m_cmp  [NUM_CH];
   logic [NUM_CH-1:0] exp_pwm = '0;
   logic              exp_pe = 1'b0;

   function automatic int model_cnt(bit mode, int p);
      if (!mode) return p;
      return (p < MAXV) ? p : (2 * MAXV - 1 - p);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run = 0; m_center = 0; m_mode = 0; m_p = 0;
         for (int i = 0; i < NUM_CH; i++) begin m_duty[i] = 0; m_cmp[i] = 0; end
         exp_pwm = '0; exp_pe = 1'b0;
      end else begin
         int  per, c, ec;
         bit  bnd, nrun, ncen;
         per = m_mode ? 2 * MAXV : MAXV;
         bnd = m_run && (m_p == per - 1);
         c   = model_cnt(m_mode, m_p);
         for (int i = 0; i < NUM_CH; i++) begin
            ec = SHADOW ? m_cmp[i] : m_duty[i];
            exp_pwm[i] = m_run && (c < ec);
         end
         exp_pe = bnd;
         nrun = m_run; ncen = m_center;
         if (wr_en) begin
            if (int'(wr_addr) < NUM_CH) m_duty[wr_addr] = int'(wr_data);
            else if (int'(wr_addr) == NUM_CH) begin nrun = wr_data[0]; ncen = wr_data[1]; end
         end
         m_center = ncen;
         if (!m_run || !nrun || bnd) begin
            m_p = 0; m_mode = ncen;
            for (int i = 0; i < NUM_CH; i++) m_cmp[i] = m_duty[i];
         end else begin
            m_p = m_p + 1;
         end
         m_run = nrun;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      checks++;
      if (pwm_out !== exp_pwm || period_end !== exp_pe) begin
         errors++;
         $display("FAIL cycle_compare t=%0t: got pwm_out=%h period_end=%b, need pwm_out=%h period_end=%b",
                  $time, pwm_out, period_end, exp_pwm, exp_pe);
      end
   end

   // Per-period high-cycle count of one channel; a window closes on a period_end cycle.
   int mon_ch = 0;
   int mon_acc = 0;
   int hi_q[$];
   always @(negedge clk) begin
      if (!rst_n) mon_acc = 0;
      else begin
         mon_acc += int'(pwm_out[mon_ch]);
         if (period_end) begin hi_q.push_back(mon_acc); mon_acc = 0; end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, need %0d", name, act, exp);
      end
   endtask

   task automatic sync();
      @(posedge clk); #1;
   endtask

   task automatic wr(input int addr, input int data);
      wr_en = 1'b1; wr_addr = ADDR_W'(addr); wr_data = CNT_W'(data);
      $display("wr addr=%0d data=0x%02h t=%0t", addr, data, $time);
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic wait_pe(input int max, input string name);
      int n = 0;
      do begin @(negedge clk); n++; end while (!period_end && n < max);
      checks++;
      if (!period_end) begin
         errors++;
         $display("FAIL %s: period_end not seen in %0d cycles (got 0, need 1)", name, max);
      end
   endtask

   task automatic pe_gap(input int max, output int gap);
      int n = 0;
      do begin @(negedge clk); n++; end while (!period_end && n < max);
      gap = n;
   endtask

   task automatic count_win(input int n, input int ch, output int hi, output int pes);
      hi = 0; pes = 0;
      repeat (n) begin
         @(negedge clk);
         hi  += int'(pwm_out[ch]);
         pes += int'(period_end);
      end
   endtask

   task automatic wait_q(input int n, input int max, input string name);
      int k = 0;
      while (hi_q.size() < n && k < max) begin sync(); k++; end
      checks++;
      if (hi_q.size() < n) begin
         errors++;
         $display("FAIL %s: got %0d period windows, need %0d", name, hi_q.size(), n);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int hi, pes, gap, busy, r, a, d;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Idle after reset.
      busy = 0;
      repeat (600) begin @(negedge clk); if (pwm_out != 0 || period_end) busy++; end
      check("reset_idle_busy_cycles", busy, 0);

      // Edge mode duty ratio and constant extremes.
      sync();
      wr(3, 'h40); wr(5, 'hFF); wr(NUM_CH, 'h01);
      wait_pe(600, "edge_start");
      pe_gap(600, gap);
      check("edge_pe_gap", gap, 255);
      count_win(255, 3, hi, pes);
      check("edge_ch3_high", hi, 64);
      check("edge_pe_per_period", pes, 1);
      count_win(255, 5, hi, pes);
      check("edge_ch5_ff_high", hi, 255);
      sync();
      wr(5, 'h00);
      wait_pe(600, "edge_ch5_clear_a");
      wait_pe(600, "edge_ch5_clear_b");
      count_win(255, 5, hi, pes);
      check("edge_ch5_00_high", hi, 0);

      // Center mode: switch applies at the next boundary.
      sync();
      wr(0, 'h40); wr(NUM_CH, 'h03);
      wait_pe(600, "center_switch");
      pe_gap(1200, gap);
      check("center_pe_gap", gap, 510);
      count_win(255, 0, hi, pes);
      check("center_first_half_high", hi, 64);
      check("center_first_half_pe", pes, 0);
      count_win(255, 0, hi, pes);
      check("center_second_half_high", hi, 64);
      check("center_second_half_pe", pes, 1);

      // Duty change mid-period at cnt 0x10.
      sync();
      wr(NUM_CH, 'h00); wr(1, 'h20); wr(NUM_CH, 'h01);
      wait_pe(600, "shadow_start");
      sync(); mon_ch = 1; hi_q.delete();
      repeat (15) sync();
      wr(1, 'h80);
      wait_q(2, 1000, "shadow_windows");
      if (hi_q.size() >= 2) begin
         check("midperiod_current_high", hi_q[0], SHADOW ? 32 : 128);
         check("midperiod_next_high", hi_q[1], 128);
      end

      // Duty write in the boundary cycle takes effect next period.
      wr(2, 'h10);
      wait_pe(600, "bnd_settle_a");
      wait_pe(600, "bnd_settle_b");
      sync(); mon_ch = 2; hi_q.delete();
      repeat (253) sync();
      wr(2, 'h30);
      wait_q(2, 1000, "bnd_windows");
      if (hi_q.size() >= 2) begin
         check("bnd_current_high", hi_q[0], 16);
         check("bnd_next_high", hi_q[1], 48);
      end

      // Write beyond CTRL is dropped.
      sync(); hi_q.delete();
      wr(NUM_CH + 1, 'h00);
      wait_q(2, 1000, "oob_windows");
      if (hi_q.size() >= 2) check("oob_ch2_high", hi_q[1], 48);

      // Randomized writes; the per-cycle compare covers them.
      for (int t = 0; t < 1200; t++) begin
         repeat ($urandom_range(0, 12)) sync();
         r = $urandom_range(0, 99);
         if (r < 8) begin
            a = NUM_CH;
            d = ($urandom_range(0, 4) != 0 ? 1 : 0) | ($urandom_range(0, 1) << 1) | ($urandom_range(0, 63) << 2);
         end else if (r < 12) begin
            a = NUM_CH + 1 + $urandom_range(0, 2);
            d = $urandom_range(0, 255);
         end else begin
            a = $urandom_range(0, NUM_CH - 1);
            r = $urandom_range(0, 9);
            d = (r == 0) ? 0 : (r == 1) ? 255 : $urandom_range(0, 255);
         end
         wr(a, d);
      end

      // Reset asserted mid-period at cnt 0x7F.
      wr(NUM_CH, 'h01); wr(1, 'h80);
      wait_pe(1200, "rst_settle_a");
      wait_pe(1200, "rst_settle_b");
      sync();
      repeat (126) sync();
      check("pre_reset_ch1", int'(pwm_out[1]), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_pwm", int'(pwm_out), 0);
      check("async_reset_pe", int'(period_end), 0);
      sync(); sync();
      rst_n = 1'b1;
      busy = 0;
      repeat (300) begin @(negedge clk); if (pwm_out != 0 || period_end) busy++; end
      check("post_reset_stopped", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
